// File: rtl/e203_tb_irq_stim_mon.sv
// Testbench-side interrupt stimulus generator and test monitor for an E203 core:
// tracks tohost commits, performance counters, pass/fail/timeout and drives per-channel random IRQs.
module e203_tb_irq_stim_mon #(
  parameter int unsigned PC_W      = 32,
  parameter int unsigned N_IRQ     = 3,
  parameter int unsigned END_HITS  = 8,
  parameter int unsigned STOP_HITS = 32,
  parameter int unsigned WDOG_BIT  = 20,
  parameter int unsigned DLY_W     = 10,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmt_valid,
  input  logic [PC_W-1:0]         cmt_pc,
  input  logic                    i_valid,
  input  logic                    i_ready,
  input  logic [31:0]             x3,
  input  logic [PC_W-1:0]         cfg_tohost_pc,
  input  logic [PC_W-1:0]         cfg_start_pc,
  input  logic [N_IRQ*PC_W-1:0]   cfg_handler_pc,
  output logic [N_IRQ-1:0]        irq_out,
  output logic [31:0]             cycle_cnt,
  output logic [31:0]             instr_cnt,
  output logic [31:0]             end_cycle,
  output logic [31:0]             tohost_cnt,
  output logic                    done,
  output logic                    pass,
  output logic                    timeout
);

  typedef enum logic [1:0] {ST_ARM, ST_DELAY, ST_ASSERT, ST_STOP} ch_state_e;
  typedef logic [DLY_W:0] dly_t;

  // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [15:0] lfsr_seed(input int unsigned idx);
    logic [15:0] s;
    s = SEED ^ 16'(idx);
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] instr_cnt_q, instr_cnt_d;
  logic [31:0] end_cycle_q, end_cycle_d;
  logic [31:0] tohost_cnt_q, tohost_cnt_d;
  logic        seen_q, seen_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        timeout_q, timeout_d;

  logic        tohost_hit, start_hit, done_set, stop_cond;
  logic [N_IRQ-1:0] handler_hit;

  ch_state_e   state_q [N_IRQ];
  ch_state_e   state_d [N_IRQ];
  dly_t        dly_q   [N_IRQ];
  dly_t        dly_d   [N_IRQ];
  logic [15:0] lfsr_q  [N_IRQ];
  logic [15:0] lfsr_d  [N_IRQ];
  logic [N_IRQ-1:0] irq_q, irq_d;

  // ---------------------------------------------------------------------------
  // Monitor: counters and sticky status flags
  // ---------------------------------------------------------------------------
  always_comb begin
    tohost_hit   = cmt_valid && (cmt_pc == cfg_tohost_pc);
    start_hit    = cmt_valid && (cmt_pc == cfg_start_pc);

    cycle_cnt_d  = cycle_cnt_q + 32'd1;

    tohost_cnt_d = tohost_cnt_q;
    if (tohost_hit && (tohost_cnt_q != 32'hFFFF_FFFF))
      tohost_cnt_d = tohost_cnt_q + 32'd1;

    end_cycle_d  = end_cycle_q;
    seen_d       = seen_q;
    if (tohost_hit && !seen_q) begin
      end_cycle_d = cycle_cnt_q;
      seen_d      = 1'b1;
    end

    // seen_q is still 0 during the first hit, so that cycle's issue is counted.
    instr_cnt_d  = instr_cnt_q;
    if (i_valid && i_ready && !seen_q)
      instr_cnt_d = instr_cnt_q + 32'd1;

    done_set  = tohost_hit && (tohost_cnt_q != tohost_cnt_d) &&
                (tohost_cnt_d == 32'(END_HITS)) && !done_q && !timeout_q;
    done_d    = done_q | done_set;
    pass_d    = done_set ? (x3 == 32'd1) : pass_q;
    // Watchdog raises together with the counter bit; a simultaneous done wins.
    timeout_d = timeout_q | (cycle_cnt_d[WDOG_BIT] && !done_q && !done_set);

    stop_cond = (tohost_cnt_q > 32'(STOP_HITS)) || done_q || timeout_q;
  end

  // ---------------------------------------------------------------------------
  // Stimulus: one FSM + LFSR per interrupt channel
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < int'(N_IRQ); i++)
      handler_hit[i] = cmt_valid && (cmt_pc == cfg_handler_pc[i*PC_W +: PC_W]);
  end

  // NOTE: every per-channel next-state is given its hold value before the case so no path leaves it unassigned (no latch).
  always_comb begin
    for (int i = 0; i < int'(N_IRQ); i++) begin
      state_d[i] = state_q[i];
      dly_d[i]   = dly_q[i];
      lfsr_d[i]  = lfsr_step(lfsr_q[i]);
      unique case (state_q[i])
        ST_ARM: begin
          if (start_hit) begin
            state_d[i] = ST_DELAY;
            dly_d[i]   = dly_t'(lfsr_q[i][DLY_W-1:0]) + dly_t'(1);
          end
        end
        ST_DELAY: begin
          if (stop_cond)
            state_d[i] = ST_STOP;
          else if (dly_q[i] == dly_t'(1))
            state_d[i] = ST_ASSERT;
          else
            dly_d[i] = dly_q[i] - dly_t'(1);
        end
        ST_ASSERT: begin
          if (stop_cond)
            state_d[i] = ST_STOP;
          else if (handler_hit[i]) begin
            state_d[i] = ST_DELAY;
            dly_d[i]   = dly_t'(lfsr_q[i][DLY_W-1:0]) + dly_t'(1);
          end
        end
        ST_STOP: state_d[i] = ST_STOP;
        default: state_d[i] = ST_ARM;
      endcase
      irq_d[i] = (state_d[i] == ST_ASSERT);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q  <= '0;
      instr_cnt_q  <= '0;
      end_cycle_q  <= '0;
      tohost_cnt_q <= '0;
      seen_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
      irq_q        <= '0;
      for (int i = 0; i < int'(N_IRQ); i++) begin
        state_q[i] <= ST_ARM;
        dly_q[i]   <= '0;
        lfsr_q[i]  <= lfsr_seed(i);
      end
    end else begin
      cycle_cnt_q  <= cycle_cnt_d;
      instr_cnt_q  <= instr_cnt_d;
      end_cycle_q  <= end_cycle_d;
      tohost_cnt_q <= tohost_cnt_d;
      seen_q       <= seen_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      timeout_q    <= timeout_d;
      irq_q        <= irq_d;
      for (int i = 0; i < int'(N_IRQ); i++) begin
        state_q[i] <= state_d[i];
        dly_q[i]   <= dly_d[i];
        lfsr_q[i]  <= lfsr_d[i];
      end
    end
  end

  assign irq_out    = irq_q;
  assign cycle_cnt  = cycle_cnt_q;
  assign instr_cnt  = instr_cnt_q;
  assign end_cycle  = end_cycle_q;
  assign tohost_cnt = tohost_cnt_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign timeout    = timeout_q;

endmodule
